// File: rtl/modulo_varredura_display_7seg.sv
// Scan stage of the 7-segment path: prescaled digit rotation over four BCD digits,
// producing the anode select index, the matching nibble and a blank flag.
module modulo_varredura_display_7seg #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [15:0] BCD_IN,
  input  logic [3:0]  DIG_EN,
  output logic [1:0]  STAC,
  output logic [3:0]  BCD_OUT,
  output logic        BLANK,
  output logic        TICK
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       stac_q, stac_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             blank_q, blank_d;
  logic             tick_q, tick_d;

  logic             wrap;
  logic [1:0]       next_idx;
  logic [1:0]       probe_idx;
  logic [3:0]       nib_sel;

  assign wrap = EN && (cnt_q == CNT_LAST);

  // Nearest enabled digit after the current one; with none enabled the index holds.
  always_comb begin
    next_idx  = stac_q;
    probe_idx = stac_q;
    for (int k = 3; k >= 1; k--) begin
      probe_idx = stac_q + 2'(k);
      if (DIG_EN[probe_idx]) next_idx = probe_idx;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d   = cnt_q;
    stac_d  = stac_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    blank_d = 1'b1;
    if (wrap) stac_d = next_idx;
    nib_sel = BCD_IN[{stac_d, 2'b00} +: 4];
    if (EN) begin
      cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
      tick_d  = wrap;
      bcd_d   = nib_sel;
      blank_d = ~DIG_EN[stac_d] | (nib_sel > 4'd9);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      stac_q  <= 2'b00;
      bcd_q   <= 4'h0;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stac_q  <= stac_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
    end
  end

  assign STAC    = stac_q;
  assign BCD_OUT = bcd_q;
  assign BLANK   = blank_q;
  assign TICK    = tick_q;

endmodule
